// File: rtl/RoCE_params.sv
// Shared types and the IB RNR timer table for the RoCE RNR retry controller.
package RoCE_params;

  localparam real NET_CLOCK_PERIOD = 4.0;

  typedef enum logic [1:0] {
    RNR_IDLE  = 2'd0,
    RNR_WAIT  = 2'd1,
    RNR_REQ   = 2'd2,
    RNR_ERROR = 2'd3
  } rnr_state_t;

  // IB RNR timer values in units of 10 us; code 0 is the longest delay (655.36 ms).
  localparam int unsigned RNR_TIMER_10US [32] = '{
    65536,     1,     2,     3,     4,     6,     8,    12,
       16,    24,    32,    48,    64,    96,   128,   192,
      256,   384,   512,   768,  1024,  1536,  2048,  3072,
     4096,  6144,  8192, 12288, 16384, 24576, 32768, 49152
  };

  // Timer code -> clock cycles: floored, never below 1, saturated to 32 bits.
  function automatic logic [31:0] rnr_timer2clk(input logic [4:0] code, input real period);
    real    cyc_real;
    longint cyc_int;
    cyc_real = real'(RNR_TIMER_10US[code]) * 10000.0 / period;
    if (cyc_real >= 4294967295.0) return '1;
    cyc_int = longint'(cyc_real);
    if (real'(cyc_int) > cyc_real) cyc_int = cyc_int - 1;
    if (cyc_int < 1) return 32'd1;
    return 32'(cyc_int);
  endfunction

endpackage

// File: rtl/roce_rnr_retry_ctrl.sv
// RoCE RNR NAK retry controller: waits the RNR timer, then asks TX to resume
// from the NAK'd PSN, and flags a QP error once the retry budget is spent.
//
// state | meaning
// IDLE  | accepting RNR NAKs
// WAIT  | RNR timer running, TX stalled
// REQ   | retransmit request presented, waiting for TX to take it
// ERROR | retry limit exhausted, held until reconfigured
module roce_rnr_retry_ctrl
  import RoCE_params::*;
#(
  parameter real CLOCK_PERIOD = NET_CLOCK_PERIOD,
  parameter int  PSN_W        = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [2:0]       cfg_rnr_retry,
  input  logic             rnr_nak_valid,
  output logic             rnr_nak_ready,
  input  logic [4:0]       rnr_nak_timer,
  input  logic [PSN_W-1:0] rnr_nak_psn,
  input  logic             ack_valid,
  output logic             retx_req_valid,
  input  logic             retx_req_ready,
  output logic [PSN_W-1:0] retx_req_psn,
  output logic             busy,
  output logic             rnr_error
);

  localparam logic [2:0] RETRY_INFINITE = 3'd7;

  // Timer code -> cycle count ROM, fully resolved at elaboration.
  logic [31:0] w_rom [32];
  for (genvar g = 0; g < 32; g++) begin : g_rom
    localparam logic [31:0] ENTRY = rnr_timer2clk(5'(g), CLOCK_PERIOD);
    assign w_rom[g] = ENTRY;
  end

  rnr_state_t       r_state;
  rnr_state_t       w_state_nxt;
  logic [2:0]       r_limit;
  logic [2:0]       r_retries_left;
  logic [31:0]      r_cnt;
  logic [PSN_W-1:0] r_psn;

  logic             w_nak_hs;
  logic             w_infinite;
  logic             w_exhausted;
  logic [2:0]       w_retries_base;

  // An ACK in the same cycle as a NAK restores the budget before the NAK consumes it.
  assign w_nak_hs       = rnr_nak_valid && (r_state == RNR_IDLE);
  assign w_infinite     = (r_limit == RETRY_INFINITE);
  assign w_retries_base = ack_valid ? r_limit : r_retries_left;
  assign w_exhausted    = (w_retries_base == 3'd0) && !w_infinite;
  assign retx_req_psn   = r_psn;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RNR_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs; reconfiguration overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    rnr_nak_ready  = 1'b0;
    retx_req_valid = 1'b0;
    busy           = 1'b0;
    rnr_error      = 1'b0;
    case (r_state)
      RNR_IDLE: begin
        rnr_nak_ready = 1'b1;
        if (w_nak_hs) w_state_nxt = w_exhausted ? RNR_ERROR : RNR_WAIT;
      end
      RNR_WAIT: begin
        busy = 1'b1;
        if (r_cnt <= 32'd1) w_state_nxt = RNR_REQ;
      end
      RNR_REQ: begin
        busy           = 1'b1;
        retx_req_valid = 1'b1;
        if (retx_req_ready) w_state_nxt = RNR_IDLE;
      end
      RNR_ERROR: begin
        rnr_error = 1'b1;
      end
      default: w_state_nxt = RNR_IDLE;
    endcase
    if (cfg_valid) w_state_nxt = RNR_IDLE;
  end

  // Retry budget, RNR timer down-counter and resume PSN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_limit        <= RETRY_INFINITE;
      r_retries_left <= RETRY_INFINITE;
      r_cnt          <= 32'd0;
      r_psn          <= '0;
    end else if (cfg_valid) begin
      r_limit        <= cfg_rnr_retry;
      r_retries_left <= cfg_rnr_retry;
      r_cnt          <= 32'd0;
    end else begin
      if (ack_valid && (r_state != RNR_ERROR)) r_retries_left <= r_limit;
      if (w_nak_hs && !w_exhausted) begin
        r_psn <= rnr_nak_psn;
        r_cnt <= w_rom[rnr_nak_timer];
        if (!w_infinite) r_retries_left <= w_retries_base - 3'd1;
      end
      if (r_state == RNR_WAIT) r_cnt <= (r_cnt <= 32'd1) ? 32'd0 : r_cnt - 32'd1;
    end
  end

endmodule

// File: tb/tb_roce_rnr_retry_ctrl.sv
// Bench for roce_rnr_retry_ctrl at a 10 ns clock.
module tb_roce_rnr_retry_ctrl;

  localparam int UNITS_10US [32] = '{
    65536,     1,     2,     3,     4,     6,     8,    12,
       16,    24,    32,    48,    64,    96,   128,   192,
      256,   384,   512,   768,  1024,  1536,  2048,  3072,
     4096,  6144,  8192, 12288, 16384, 24576, 32768, 49152
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [2:0]  cfg_rnr_retry;
  logic        rnr_nak_valid;
  logic        rnr_nak_ready;
  logic [4:0]  rnr_nak_timer;
  logic [23:0] rnr_nak_psn;
  logic        ack_valid;
  logic        retx_req_valid;
  logic        retx_req_ready;
  logic [23:0] retx_req_psn;
  logic        busy;
  logic        rnr_error;

  int checks = 0;
  int errors = 0;

  roce_rnr_retry_ctrl #(.CLOCK_PERIOD(10.0), .PSN_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_rnr_retry(cfg_rnr_retry),
    .rnr_nak_valid(rnr_nak_valid), .rnr_nak_ready(rnr_nak_ready),
    .rnr_nak_timer(rnr_nak_timer), .rnr_nak_psn(rnr_nak_psn),
    .ack_valid(ack_valid),
    .retx_req_valid(retx_req_valid), .retx_req_ready(retx_req_ready),
    .retx_req_psn(retx_req_psn),
    .busy(busy), .rnr_error(rnr_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [2:0]  lim;
    logic        nv;
    logic [4:0]  code;
    logic [23:0] psn;
    logic        ack;
    logic        rdy;
    int          gap;
    logic        e_ready;
    logic        e_valid;
    logic        e_busy;
    logic        e_err;
    logic [23:0] e_psn;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int cv, int lim, int nv, int code, int psn, int ack, int rdy,
                              int gap, int er, int ev, int eb, int ee, int epsn);
    vec_t v;
    v.cv = 1'(cv); v.lim = 3'(lim); v.nv = 1'(nv); v.code = 5'(code); v.psn = 24'(psn);
    v.ack = 1'(ack); v.rdy = 1'(rdy); v.gap = gap;
    v.e_ready = 1'(er); v.e_valid = 1'(ev); v.e_busy = 1'(eb); v.e_err = 1'(ee);
    v.e_psn = 24'(epsn);
    return v;
  endfunction

  function automatic int exp_n(int code);
    return UNITS_10US[code] * 1000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cfg_valid     = 1'b0;
    rnr_nak_valid = 1'b0;
    ack_valid     = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_nak(input int code, input int psn);
    rnr_nak_valid = 1'b1;
    rnr_nak_timer = 5'(code);
    rnr_nak_psn   = 24'(psn);
    step();
    drive_idle();
  endtask

  task automatic send_cfg(input int lim);
    cfg_valid     = 1'b1;
    cfg_rnr_retry = 3'(lim);
    step();
    drive_idle();
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!retx_req_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  // Model state for the randomized section.
  int          m_lim, m_cred, m_cd;
  bit          m_err, m_out;
  logic [23:0] m_psn;

  initial begin
    int n;
    int bad;
    int shown;
    bit exp_ready, exp_valid;

    rst_n = 1'b0;
    drive_idle();
    cfg_rnr_retry  = 3'd0;
    rnr_nak_timer  = 5'd0;
    rnr_nak_psn    = 24'd0;
    retx_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(rnr_nak_ready), 32'd1);
    chk("reset_valid", 32'(retx_req_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_error", 32'(rnr_error), 32'd0);
    chk("reset_psn", 32'(retx_req_psn), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_reset_ready", 32'(rnr_nak_ready), 32'd1);

    for (int c = 0; c < 32; c++) chk($sformatf("rom[%0d]", c), dut.w_rom[c], 32'(exp_n(c)));

    // cfg, lim, nak, code, psn, ack, rdy, gap | ready, valid, busy, err, psn
    vt.push_back(mk(1, 3, 0, 0, 0,     0, 0, 0,    1, 0, 0, 0, 'h0));
    vt.push_back(mk(0, 0, 1, 1, 'h100, 0, 0, 0,    0, 0, 1, 0, 'h100));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 998,  0, 0, 1, 0, 'h100));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,    0, 1, 1, 0, 'h100));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 1, 0,    1, 0, 0, 0, 'h100));
    vt.push_back(mk(1, 1, 0, 0, 0,     0, 0, 0,    1, 0, 0, 0, 'h100));
    vt.push_back(mk(0, 0, 1, 2, 'h222, 0, 0, 0,    0, 0, 1, 0, 'h222));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 1998, 0, 0, 1, 0, 'h222));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,    0, 1, 1, 0, 'h222));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 1, 0,    1, 0, 0, 0, 'h222));
    vt.push_back(mk(0, 0, 1, 2, 'h333, 0, 0, 0,    0, 0, 0, 1, 'h222));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 100,  0, 0, 0, 1, 'h222));
    vt.push_back(mk(0, 0, 0, 0, 0,     1, 0, 0,    0, 0, 0, 1, 'h222));
    vt.push_back(mk(0, 0, 1, 1, 'h444, 0, 0, 0,    0, 0, 0, 1, 'h222));
    vt.push_back(mk(1, 1, 0, 0, 0,     0, 0, 0,    1, 0, 0, 0, 'h222));
    vt.push_back(mk(0, 0, 1, 1, 'h500, 0, 0, 0,    0, 0, 1, 0, 'h500));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 999,  0, 1, 1, 0, 'h500));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 1, 0,    1, 0, 0, 0, 'h500));
    vt.push_back(mk(0, 0, 0, 0, 0,     1, 0, 0,    1, 0, 0, 0, 'h500));
    vt.push_back(mk(0, 0, 1, 1, 'h501, 0, 0, 0,    0, 0, 1, 0, 'h501));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 999,  0, 1, 1, 0, 'h501));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 1, 0,    1, 0, 0, 0, 'h501));
    vt.push_back(mk(0, 0, 1, 1, 'h502, 1, 0, 0,    0, 0, 1, 0, 'h502));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 999,  0, 1, 1, 0, 'h502));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 1, 0,    1, 0, 0, 0, 'h502));
    vt.push_back(mk(0, 0, 1, 1, 'h503, 0, 0, 0,    0, 0, 0, 1, 'h502));
    vt.push_back(mk(1, 0, 0, 0, 0,     0, 0, 0,    1, 0, 0, 0, 'h502));
    vt.push_back(mk(0, 0, 1, 1, 'h600, 0, 0, 0,    0, 0, 0, 1, 'h502));
    vt.push_back(mk(1, 7, 0, 0, 0,     0, 0, 0,    1, 0, 0, 0, 'h502));
    vt.push_back(mk(1, 0, 0, 0, 0,     0, 0, 0,    1, 0, 0, 0, 'h502));
    vt.push_back(mk(0, 0, 1, 1, 'h601, 1, 0, 0,    0, 0, 0, 1, 'h502));
    vt.push_back(mk(1, 1, 0, 0, 0,     0, 0, 0,    1, 0, 0, 0, 'h502));
    vt.push_back(mk(0, 0, 1, 1, 'h700, 0, 0, 0,    0, 0, 1, 0, 'h700));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 400,  0, 0, 1, 0, 'h700));
    vt.push_back(mk(0, 0, 0, 0, 0,     1, 0, 0,    0, 0, 1, 0, 'h700));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 597,  0, 1, 1, 0, 'h700));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 1, 0,    1, 0, 0, 0, 'h700));
    vt.push_back(mk(0, 0, 1, 1, 'h701, 0, 0, 0,    0, 0, 1, 0, 'h701));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 0, 999,  0, 1, 1, 0, 'h701));
    vt.push_back(mk(0, 0, 0, 0, 0,     0, 1, 0,    1, 0, 0, 0, 'h701));

    foreach (vt[i]) begin
      cfg_valid      = vt[i].cv;
      cfg_rnr_retry  = vt[i].lim;
      rnr_nak_valid  = vt[i].nv;
      rnr_nak_timer  = vt[i].code;
      rnr_nak_psn    = vt[i].psn;
      ack_valid      = vt[i].ack;
      retx_req_ready = vt[i].rdy;
      step();
      drive_idle();
      retx_req_ready = 1'b0;
      repeat (vt[i].gap) step();
      checks++;
      if ({rnr_nak_ready, retx_req_valid, busy, rnr_error, retx_req_psn} !==
          {vt[i].e_ready, vt[i].e_valid, vt[i].e_busy, vt[i].e_err, vt[i].e_psn}) begin
        errors++;
        $display("FAIL vec[%0d] actual rdy=%0b val=%0b busy=%0b err=%0b psn=%0h required rdy=%0b val=%0b busy=%0b err=%0b psn=%0h",
                 i, rnr_nak_ready, retx_req_valid, busy, rnr_error, retx_req_psn,
                 vt[i].e_ready, vt[i].e_valid, vt[i].e_busy, vt[i].e_err, vt[i].e_psn);
      end
    end

    // Request held off by TX for 50 cycles, with a NAK pending meanwhile.
    send_cfg(3);
    send_nak(1, 'hABC);
    wait_valid(1100, n);
    chk("stall_latency", 32'(n), 32'd1000);
    rnr_nak_valid = 1'b1;
    rnr_nak_psn   = 24'hDEF;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (!(retx_req_valid && busy && !rnr_nak_ready && retx_req_psn == 24'hABC)) bad++;
    end
    chk("stall_hold_bad_cycles", 32'(bad), 32'd0);
    rnr_nak_valid  = 1'b0;
    retx_req_ready = 1'b1;
    step();
    retx_req_ready = 1'b0;
    chk("stall_release_busy", 32'(busy), 32'd0);
    chk("stall_release_psn", 32'(retx_req_psn), 32'hABC);

    // Reconfiguration in the middle of the wait.
    send_nak(1, 'h111);
    repeat (499) step();
    chk("cfg_mid_wait_busy_before", 32'(busy), 32'd1);
    send_cfg(3);
    chk("cfg_mid_wait_ready", 32'(rnr_nak_ready), 32'd1);
    chk("cfg_mid_wait_busy", 32'(busy), 32'd0);
    bad = 0;
    for (int k = 0; k < 1500; k++) begin
      step();
      if (retx_req_valid) bad++;
    end
    chk("cfg_mid_wait_no_retx", 32'(bad), 32'd0);

    // Reset in the middle of the wait.
    send_nak(1, 'h222);
    repeat (300) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wait_busy", 32'(busy), 32'd0);
    chk("rst_mid_wait_ready", 32'(rnr_nak_ready), 32'd1);
    chk("rst_mid_wait_psn", 32'(retx_req_psn), 32'd0);
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 1500; k++) begin
      step();
      if (retx_req_valid || busy) bad++;
    end
    chk("rst_mid_wait_no_retx", 32'(bad), 32'd0);

    // Reset while the request is presented.
    send_nak(1, 'h333);
    wait_valid(1100, n);
    chk("rst_mid_req_latency", 32'(n), 32'd1000);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_valid", 32'(retx_req_valid), 32'd0);
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (retx_req_valid) bad++;
    end
    chk("rst_mid_req_no_retx", 32'(bad), 32'd0);

    // Infinite retry limit.
    send_cfg(7);
    for (int k = 0; k < 10; k++) begin
      send_nak(1, 'h10 + k);
      chk($sformatf("inf[%0d]_accepted", k), 32'(busy), 32'd1);
      wait_valid(1100, n);
      chk($sformatf("inf[%0d]_latency", k), 32'(n), 32'd1000);
      chk($sformatf("inf[%0d]_psn", k), 32'(retx_req_psn), 32'h10 + 32'(k));
      retx_req_ready = 1'b1;
      step();
      retx_req_ready = 1'b0;
      chk($sformatf("inf[%0d]_error", k), 32'(rnr_error), 32'd0);
    end

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_lim = 7; m_cred = 7; m_err = 0; m_out = 0; m_cd = 0; m_psn = 24'd0;
    shown = 0;
    for (int cyc = 0; cyc < 25000; cyc++) begin
      exp_ready = !m_err && !m_out;
      exp_valid = m_out && (m_cd == 0);
      checks++;
      if (rnr_nak_ready !== exp_ready || retx_req_valid !== exp_valid || busy !== m_out ||
          rnr_error !== m_err || retx_req_psn !== m_psn) begin
        errors++;
        if (shown < 8) begin
          shown++;
          $display("FAIL rand cyc %0d actual rdy=%0b val=%0b busy=%0b err=%0b psn=%0h required rdy=%0b val=%0b busy=%0b err=%0b psn=%0h",
                   cyc, rnr_nak_ready, retx_req_valid, busy, rnr_error, retx_req_psn,
                   exp_ready, exp_valid, m_out, m_err, m_psn);
        end
      end
      cfg_valid      = ($urandom_range(0, 2999) == 0);
      cfg_rnr_retry  = 3'($urandom_range(0, 7));
      ack_valid      = ($urandom_range(0, 799) == 0);
      rnr_nak_valid  = ($urandom_range(0, 5) == 0);
      rnr_nak_timer  = 5'($urandom_range(1, 2));
      rnr_nak_psn    = 24'($urandom);
      retx_req_ready = ($urandom_range(0, 2) == 0);
      if (cfg_valid) begin
        m_lim = int'(cfg_rnr_retry); m_cred = m_lim; m_err = 0; m_out = 0;
      end else if (!m_err) begin
        if (ack_valid) m_cred = m_lim;
        if (m_out) begin
          if (m_cd > 0) m_cd--;
          else if (retx_req_ready) m_out = 0;
        end else if (rnr_nak_valid) begin
          if (m_cred == 0 && m_lim != 7) m_err = 1;
          else begin
            m_psn = rnr_nak_psn;
            m_cd  = exp_n(int'(rnr_nak_timer));
            m_out = 1;
            if (m_lim != 7) m_cred--;
          end
        end
      end
      step();
    end
    drive_idle();
    retx_req_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
